// File: rtl/crc8_serial_engine.sv
// Bit-serial CRC-8 engine: MSB-first, programmable seed and polynomial.
// Optional serial result output enabled by defining CRC_SERIAL_OUT_EN.
module crc8_serial_engine #(
    parameter int FRAME_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] crc_init,
    input  logic [7:0] crc_poly,
    input  logic       data_in,
    input  logic       crc_enable,
`ifdef CRC_SERIAL_OUT_EN
    output logic       crc_sout,
    output logic       crc_sout_valid,
`endif
    output logic [7:0] crc_out,
    output logic       crc_valid,
    output logic [7:0] frame_count,
    output logic       busy
);

    localparam logic [7:0] FB = 8'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] crc_reg_q, crc_reg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] crc_out_q, crc_out_d;
    logic       crc_valid_q, crc_valid_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [7:0] base;
    logic [7:0] nxt;
    logic [7:0] cnt_inc;

    // One CRC step; outside CALC the step starts from the live seed
    always_comb begin
        base = (state_q == CALC) ? crc_reg_q : crc_init;
        nxt  = {base[6:0], 1'b0} ^ ((base[7] ^ data_in) ? crc_poly : 8'h00);
        cnt_inc = cnt_q + 8'd1;
    end

    // Next-state, working register, bit counter and report values
    always_comb begin
        state_d       = state_q;
        crc_reg_d     = crc_reg_q;
        cnt_d         = cnt_q;
        crc_out_d     = crc_out_q;
        crc_valid_d   = 1'b0;
        frame_count_d = frame_count_q;
        unique case (state_q)
            IDLE, DONE: begin
                crc_reg_d = crc_init;
                cnt_d     = 8'd0;
                state_d   = IDLE;
                if (crc_enable) begin
                    crc_reg_d = nxt;
                    cnt_d     = 8'd1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (crc_enable) begin
                    crc_reg_d = nxt;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == FB) begin
                        state_d       = DONE;
                        crc_out_d     = nxt;
                        crc_valid_d   = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Core state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            crc_reg_q     <= 8'h00;
            cnt_q         <= 8'd0;
            crc_out_q     <= 8'h00;
            crc_valid_q   <= 1'b0;
            frame_count_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            crc_reg_q     <= crc_reg_d;
            cnt_q         <= cnt_d;
            crc_out_q     <= crc_out_d;
            crc_valid_q   <= crc_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign crc_out     = crc_out_q;
    assign crc_valid   = crc_valid_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q == CALC) ||
                         ((state_q == DONE) && crc_enable);

`ifdef CRC_SERIAL_OUT_EN
    logic [7:0] sh_q, sh_d;
    logic [3:0] sh_cnt_q, sh_cnt_d;

    // Shift the result out MSB-first; a new result restarts the shift
    always_comb begin
        sh_d     = sh_q;
        sh_cnt_d = sh_cnt_q;
        if (crc_valid_q) begin
            sh_d     = crc_out_q;
            sh_cnt_d = 4'd8;
        end else if (sh_cnt_q != 4'd0) begin
            sh_d     = {sh_q[6:0], 1'b0};
            sh_cnt_d = sh_cnt_q - 4'd1;
        end
    end

    // Shift-out registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q     <= 8'h00;
            sh_cnt_q <= 4'd0;
        end else begin
            sh_q     <= sh_d;
            sh_cnt_q <= sh_cnt_d;
        end
    end

    assign crc_sout       = sh_q[7];
    assign crc_sout_valid = (sh_cnt_q != 4'd0);
`endif

endmodule

// File: tb/tb_crc8_serial_engine.sv
// Randomized self-checking bench for crc8_serial_engine.
// Frame CRCs come from a bit-list reference computed at frame end.
module tb_crc8_serial_engine;

    localparam int FB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] crc_init = 8'h00;
    logic [7:0] crc_poly = 8'h07;
    logic       data_in = 1'b0;
    logic       en8 = 1'b0;
    logic       en72 = 1'b0;

    logic [7:0] crc_out8, fcnt8, crc_out72, fcnt72;
    logic       valid8, busy8, valid72, busy72;
    logic       sout8, soutv8, sout72, soutv72;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc8_serial_engine #(.FRAME_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .crc_init(crc_init), .crc_poly(crc_poly),
        .data_in(data_in), .crc_enable(en8),
`ifdef CRC_SERIAL_OUT_EN
        .crc_sout(sout8), .crc_sout_valid(soutv8),
`endif
        .crc_out(crc_out8), .crc_valid(valid8),
        .frame_count(fcnt8), .busy(busy8)
    );

    crc8_serial_engine #(.FRAME_BITS(72)) dut72 (
        .clk(clk), .rst(rst),
        .crc_init(crc_init), .crc_poly(crc_poly),
        .data_in(data_in), .crc_enable(en72),
`ifdef CRC_SERIAL_OUT_EN
        .crc_sout(sout72), .crc_sout_valid(soutv72),
`endif
        .crc_out(crc_out72), .crc_valid(valid72),
        .frame_count(fcnt72), .busy(busy72)
    );

`ifndef CRC_SERIAL_OUT_EN
    assign sout8 = 1'b0;
    assign soutv8 = 1'b0;
    assign sout72 = 1'b0;
    assign soutv72 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] crc;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       expq[$];
    logic       acc_bits[$];
    logic [7:0] acc_poly[$];
    logic [7:0] seed;
    logic [7:0] exp_cnt = 8'h00;
    logic       in_done = 1'b0;
    logic [7:0] sh_val = 8'h00;
    int         sh_left = 0;
    int         v72 = 0;
    logic [7:0] last72 = 8'h00;
    logic [7:0] s72 = 8'h00;
    int         n72v = 0;

    // Long division of the seeded message, one bit at a time
    function automatic logic [7:0] ref_crc();
        logic [7:0] r;
        r = seed;
        for (int i = 0; i < acc_bits.size(); i++) begin
            if (r[7] ^ acc_bits[i])
                r = (r << 1) ^ acc_poly[i];
            else
                r = r << 1;
        end
        return r;
    endfunction

    task automatic drive(input logic en, input logic b);
        logic exp_busy;
        exp_busy = (acc_bits.size() > 0) || (in_done && en);
        en8 = en;
        data_in = b;
        in_done = 1'b0;
        if (en) begin
            if (acc_bits.size() == 0) seed = crc_init;
            acc_bits.push_back(b);
            acc_poly.push_back(crc_poly);
            if (acc_bits.size() == FB) begin
                exp_cnt = exp_cnt + 8'd1;
                expq.push_back('{ref_crc(), exp_cnt, cyc + 1});
                acc_bits.delete();
                acc_poly.delete();
                in_done = 1'b1;
            end
        end
        #2;
        check("busy", busy8, exp_busy);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive(1'b1, v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en8 = 1'b0;
        en72 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_bits.delete();
        acc_poly.delete();
        exp_cnt = 8'h00;
        in_done = 1'b0;
        sh_left = 0;
        check("rst_crc", crc_out8, 8'h00);
        check("rst_valid", valid8, 1'b0);
        check("rst_fcnt", fcnt8, 8'h00);
        check("rst_busy", busy8, 1'b0);
        check("rst_sv", soutv8, 1'b0);
    endtask

    // Scoreboard for the 8-bit instance: value, count, latency, shift-out
    always @(negedge clk) begin
        if (!rst) begin
            if (valid8) begin
                if (expq.size() == 0) begin
                    check("spurious_valid", valid8, 1'b0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("crc", crc_out8, e.crc);
                    check("fcnt", fcnt8, e.cnt);
                    check("latency", cyc, e.cyc);
                end
            end
`ifdef CRC_SERIAL_OUT_EN
            if (sh_left > 0) begin
                check("sout_v", soutv8, 1'b1);
                check("sout", sout8, sh_val[sh_left-1]);
                sh_left--;
            end else begin
                check("sout_v_idle", soutv8, 1'b0);
            end
            if (valid8) begin
                sh_val = crc_out8;
                sh_left = 8;
            end
`endif
            if (valid72) begin
                v72++;
                last72 = crc_out72;
            end
            if (soutv72) begin
                s72 = {s72[6:0], sout72};
                n72v++;
            end
        end
    end

    task automatic run72();
        logic [71:0] m;
        int i;
        m = "123456789";
        crc_init = 8'h00;
        crc_poly = 8'h07;
        en8 = 1'b0;
        i = 71;
        while (i >= 0) begin
            en72 = ($urandom_range(0, 2) != 0);
            data_in = m[i];
            @(posedge clk);
            #1;
            if (en72) i--;
        end
        en72 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("crc72", last72, 8'hF4);
        check("valid72_count", v72, 1);
`ifdef CRC_SERIAL_OUT_EN
        check("sout72_bits", s72, 8'hF4);
        check("sout72_len", n72v, 8);
`endif
    endtask

    initial begin
        do_reset();

        // 0x01, seed 0x00, poly 0x07
        crc_init = 8'h00;
        crc_poly = 8'h07;
        send_byte(8'h01);
        drive(1'b0, 1'b0);
        check("kat01_crc", crc_out8, 8'h07);
        check("kat01_fcnt", fcnt8, 8'h01);
        check("kat01_vlo", valid8, 1'b0);

        // back-to-back frames with seed change on the boundary
        crc_init = 8'hFF;
        send_byte(8'h00);
        crc_init = 8'h00;
        send_byte(8'hFF);
        drive(1'b0, 1'b0);
        check("kat_b2b_crc", crc_out8, 8'hF3);
        check("kat_b2b_fcnt", fcnt8, 8'h03);
        repeat (10) drive(1'b0, 1'b0);

        run72();

        // mid-frame reset discards the partial frame
        crc_init = 8'h5A;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'($urandom));
        do_reset();
        crc_init = 8'h00;
        crc_poly = 8'h07;
        send_byte(8'h01);
        drive(1'b0, 1'b0);
        check("post_rst_crc", crc_out8, 8'h07);
        check("post_rst_fcnt", fcnt8, 8'h01);

        // random frames with stalls and live seed/poly changes
        for (int f = 0; f < 40; f++) begin
            crc_init = 8'($urandom);
            for (int b = 0; b < FB; b++) begin
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom));
                if ($urandom_range(0, 5) == 0) crc_poly = 8'($urandom);
                if ($urandom_range(0, 5) == 0) crc_init = 8'($urandom);
                drive(1'b1, 1'($urandom));
            end
            if ($urandom_range(0, 1) == 0) drive(1'b0, 1'b0);
        end
        repeat (10) drive(1'b0, 1'b0);

        // 256 back-to-back frames wrap the frame counter
        do_reset();
        for (int k = 0; k < 256 * FB; k++) begin
            crc_init = 8'($urandom);
            if ($urandom_range(0, 7) == 0) crc_poly = 8'($urandom);
            drive(1'b1, 1'($urandom));
        end
        drive(1'b0, 1'b0);
        check("wrap_fcnt", fcnt8, 8'h00);
        repeat (10) drive(1'b0, 1'b0);
        check("missed_valid", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
